bonus_slot_manager: RTL and testbench
=====================================

# bonus_slot_manager

Owns the 16 falling-bonus slots whose per-slot draw requests feed the bonus RGB mux. Spawns a bonus into the lowest free slot on a brick-break request and advances all falling bonuses once per frame. Attributes paddle collisions back to the individual slot that was being drawn, then reports each catch to game logic over a valid/ready handshake. It is the control end of the 16-slot bonus interface; the mux is the display end.

## Interface
Parameters:
- SLOTS, 16, number of bonus slots (one-hot width of draw-request vector)
- FALL_STEP, 2, pixels added to Y per frame
- SCREEN_BOTTOM, 479, last visible row; slot freed when Y would exceed it
- TYPE_W, 3, bonus type width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse per VGA frame
- spawnReq  in  1  level request, held until spawnAck or spawnDrop
- spawnX, spawnY  in  11 each  top-left of new bonus
- spawnType  in  TYPE_W  bonus kind
- spawnAck  out  1  one-cycle pulse: request accepted
- spawnDrop  out  1  one-cycle pulse: request rejected (all slots busy)
- bonusDrawReq  in  SLOTS  per-slot draw requests for the current pixel (same vector the mux receives)
- paddleDrawReq  in  1  paddle drawing current pixel
- slotActive  out  SLOTS  slot enable to the bonus drawers
- slotX, slotY  out  SLOTS×11  slot positions
- slotType  out  SLOTS×TYPE_W  slot kinds
- catchValid  out  1  catch event pending
- catchSlot  out  4  slot index of the event
- catchType  out  TYPE_W  type of the caught bonus
- catchReady  in  1  game logic consumes the event

## Operation
- FSM states: IDLE, MOVE, REPORT.
- IDLE:
  - If spawnReq is high, allocate the lowest-index free slot: load X/Y/type, set slotActive, pulse spawnAck.
  - If no slot is free, pulse spawnDrop instead.
  - startOfFrame (or a latched pending frame) takes priority over spawn and moves the FSM to MOVE.
- MOVE (one cycle):
  - Every active, uncaught slot: Y <= Y + FALL_STEP.
  - If Y + FALL_STEP > SCREEN_BOTTOM, clear slotActive (bonus missed).
  - Next state: REPORT if caughtMask ≠ 0, else IDLE.
- REPORT:
  - Drive catchValid with the lowest set bit of caughtMask, plus that slot's type.
  - On catchValid && catchReady: clear the slot's active and caught bits.
  - Present the next event the following cycle; return to IDLE when the mask is empty.
- Hit capture runs in all states: each cycle where paddleDrawReq is high, set caughtMask for every bit with bonusDrawReq[i] && slotActive[i]. Overlapping bonuses are all caught. Repeat hits are idempotent.
- Caught slots stay visible (stay active) and stop falling until reported.
- startOfFrame outside IDLE sets a one-deep pendingFrame flag. Further pulses while the flag is set are lost.
- Spawn requests are ignored outside IDLE; the requester keeps spawnReq held.
- Arithmetic: compute Y in 12 bits, so no wrap-around is possible.

## Timing
- All outputs are registered.
- Reset values: every output is 0, slot registers are 0, caughtMask = 0, pendingFrame = 0, state = IDLE.
- spawnAck/spawnDrop: 1 cycle after spawnReq is sampled in IDLE. The slot is active on that same edge.
- Hit: caughtMask is set 1 cycle after the coincident pixel.
- MOVE takes 1 cycle after startOfFrame is sampled.
- First catchValid: the cycle after MOVE.
- catchValid, catchSlot and catchType stay stable until a ready handshake.
- Throughput: 1 event per cycle while catchReady is held high.
- Reset mid-REPORT: the pending event is discarded and all slots are freed.

## Configuration
- BONUS_MISS_CNT_EN defined:
  - Adds output missCount, 8 bits: a saturating count of bonuses freed by passing SCREEN_BOTTOM.
  - Reset value 0; saturates at 255.
- Not defined: the port and the counter are absent, and behaviour is otherwise identical.

## Structure
- Shared package bonus_pkg holds:
  - SLOTS, TYPE_W, COORD_W = 11
  - bonus_slot_t struct {x, y, kind}
  - state enum {IDLE, MOVE, REPORT}
- One sub-module, bonus_prio_enc: a lowest-set-bit encoder returning an index plus a found flag. Two instances: free-slot selection (~slotActive) and report selection (caughtMask).

## Test plan
- Reset, then spawnReq (X=100, Y=50, type 2) in IDLE → spawnAck after 1 cycle; slotActive = 16'h0001, slotY[0] = 50.
- 16 spawns, then a 17th → spawnDrop pulse; slotActive stays 16'hFFFF.
- Slot 0 at Y=478, then startOfFrame → slotActive[0] clears (missCount = 1 when BONUS_MISS_CNT_EN is defined).
- paddleDrawReq with bonusDrawReq = 16'h0024 (slots 2 and 5 active), then startOfFrame with catchReady low for 3 cycles:
  - catchSlot = 2 is held for those 3 cycles.
  - After catchReady rises, catchSlot = 5 follows.
  - Both slots are then freed and the FSM returns to IDLE.
- startOfFrame arrives during REPORT → a second MOVE runs after REPORT drains; caught slots do not move.
- reset asserted mid-REPORT → next cycle all outputs are 0 and the state is IDLE.

Source files
------------

// File: rtl/bonus_pkg.sv
// rtl/bonus_pkg.sv - shared sizes, slot record and FSM state for the bonus slot manager
package bonus_pkg;
   localparam int SLOTS   = 16;
   localparam int TYPE_W  = 3;
   localparam int COORD_W = 11;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [TYPE_W-1:0]  kind;
   } bonus_slot_t;

   typedef enum logic [1:0] {IDLE, MOVE, REPORT} state_t;
endpackage

// File: rtl/bonus_prio_enc.sv
// rtl/bonus_prio_enc.sv - lowest-set-bit encoder returning index and found flag
module bonus_prio_enc
   import bonus_pkg::*;
#(
   parameter int WIDTH = SLOTS,
   parameter int IDX_W = 4
) (
   input  logic [WIDTH-1:0] vec,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   // scan from the top down so the lowest set bit is the last one written
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx   = IDX_W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bonus_slot_manager.sv
// rtl/bonus_slot_manager.sv - 16-slot falling bonus control; optional BONUS_MISS_CNT_EN adds missCount
module bonus_slot_manager #(
   parameter int SLOTS         = 16,
   parameter int FALL_STEP     = 2,
   parameter int SCREEN_BOTTOM = 479,
   parameter int TYPE_W        = 3
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 startOfFrame,
   input  logic                                 spawnReq,
   input  logic [bonus_pkg::COORD_W-1:0]        spawnX,
   input  logic [bonus_pkg::COORD_W-1:0]        spawnY,
   input  logic [TYPE_W-1:0]                    spawnType,
   output logic                                 spawnAck,
   output logic                                 spawnDrop,
   input  logic [SLOTS-1:0]                     bonusDrawReq,
   input  logic                                 paddleDrawReq,
   output logic [SLOTS-1:0]                     slotActive,
   output logic [SLOTS*bonus_pkg::COORD_W-1:0]  slotX,
   output logic [SLOTS*bonus_pkg::COORD_W-1:0]  slotY,
   output logic [SLOTS*TYPE_W-1:0]              slotType,
   output logic                                 catchValid,
   output logic [3:0]                           catchSlot,
   output logic [TYPE_W-1:0]                    catchType,
   input  logic                                 catchReady
`ifdef BONUS_MISS_CNT_EN
   ,
   output logic [7:0]                           missCount
`endif
);
   import bonus_pkg::*;

   state_t           state, state_nxt;
   bonus_slot_t      slots [SLOTS];
   logic [SLOTS-1:0] caught;
   logic             pending_frame;

   logic [SLOTS-1:0] hits, clear_mask, report_vec, move_mask, miss_mask, active_nxt;
   logic [11:0]      y_sum [SLOTS];
   logic [3:0]       free_idx, rep_idx;
   logic             free_found, rep_found;
   logic             frame_go, handshake, do_move, do_spawn;

   assign hits       = paddleDrawReq ? (bonusDrawReq & slotActive) : '0;
   assign handshake  = catchValid && catchReady;
   assign clear_mask = handshake ? (SLOTS'(1) << catchSlot) : '0;
   assign report_vec = caught & ~clear_mask;
   assign frame_go   = startOfFrame || pending_frame;

   bonus_prio_enc #(.WIDTH(SLOTS), .IDX_W(4)) u_free_enc (
      .vec   (~slotActive),
      .idx   (free_idx),
      .found (free_found)
   );

   bonus_prio_enc #(.WIDTH(SLOTS), .IDX_W(4)) u_rep_enc (
      .vec   (report_vec),
      .idx   (rep_idx),
      .found (rep_found)
   );

   // per-slot fall arithmetic in 12 bits so the bottom test cannot wrap
   always_comb begin
      for (int i = 0; i < SLOTS; i++) begin
         y_sum[i]     = {1'b0, slots[i].y} + 12'(FALL_STEP);
         move_mask[i] = slotActive[i] && !caught[i];
         miss_mask[i] = move_mask[i] && (y_sum[i] > 12'(SCREEN_BOTTOM));
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // next-state: frames win over spawns, REPORT drains until no catch is left
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (frame_go) state_nxt = MOVE;
         MOVE:    state_nxt = (caught != '0) ? REPORT : IDLE;
         REPORT:  if (report_vec == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // state decode; a spawn is not re-accepted while its ack/drop pulse is still out
   always_comb begin
      do_move  = 1'b0;
      do_spawn = 1'b0;
      case (state)
         IDLE:    do_spawn = !frame_go && spawnReq && !spawnAck && !spawnDrop;
         MOVE:    do_move  = 1'b1;
         default: ;
      endcase
   end

   // next active mask: reported slots freed, missed slots freed, spawned slot set
   always_comb begin
      active_nxt = slotActive & ~clear_mask;
      if (do_move) active_nxt = active_nxt & ~miss_mask;
      if (do_spawn && free_found) active_nxt[free_idx] = 1'b1;
   end

   // slot storage, hit capture, frame latch, spawn response and catch event registers
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SLOTS; i++) slots[i] <= '0;
         slotActive    <= '0;
         caught        <= '0;
         pending_frame <= 1'b0;
         spawnAck      <= 1'b0;
         spawnDrop     <= 1'b0;
         catchValid    <= 1'b0;
         catchSlot     <= '0;
         catchType     <= '0;
      end else begin
         slotActive <= active_nxt;
         caught     <= (caught | hits) & ~clear_mask;
         spawnAck   <= do_spawn && free_found;
         spawnDrop  <= do_spawn && !free_found;

         if (state == IDLE && frame_go) pending_frame <= 1'b0;
         else if (startOfFrame)         pending_frame <= 1'b1;

         for (int i = 0; i < SLOTS; i++) begin
            if (do_spawn && free_found && free_idx == 4'(i))
               slots[i] <= '{x: spawnX, y: spawnY, kind: spawnType};
            else if (do_move && move_mask[i] && !miss_mask[i])
               slots[i].y <= y_sum[i][COORD_W-1:0];
         end

         // an event is held until handshaken, then the next lowest is loaded
         if (state_nxt == REPORT) begin
            if (!catchValid || handshake) begin
               catchValid <= rep_found;
               catchSlot  <= rep_idx;
               catchType  <= slots[rep_idx].kind;
            end
         end else begin
            catchValid <= 1'b0;
            catchSlot  <= '0;
            catchType  <= '0;
         end
      end
   end

   for (genvar g = 0; g < SLOTS; g++) begin : g_flat
      assign slotX[g*COORD_W +: COORD_W] = slots[g].x;
      assign slotY[g*COORD_W +: COORD_W] = slots[g].y;
      assign slotType[g*TYPE_W +: TYPE_W] = slots[g].kind;
   end

`ifdef BONUS_MISS_CNT_EN
   logic [4:0] miss_num;
   logic [8:0] miss_sum;

   // number of bonuses leaving the screen this frame
   always_comb begin
      miss_num = '0;
      for (int i = 0; i < SLOTS; i++) miss_num = miss_num + 5'(miss_mask[i]);
      miss_sum = {1'b0, missCount} + 9'(miss_num);
   end

   // saturating miss counter
   always_ff @(posedge clk) begin
      if (reset)        missCount <= '0;
      else if (do_move) missCount <= miss_sum[8] ? 8'hFF : miss_sum[7:0];
   end
`endif

endmodule

// File: tb/tb_bonus_slot_manager.sv
// tb/tb_bonus_slot_manager.sv - scoreboard bench for bonus_slot_manager; honours BONUS_MISS_CNT_EN
module tb_bonus_slot_manager;
   import bonus_pkg::*;

   logic         clk = 1'b0;
   logic         reset, startOfFrame, spawnReq, paddleDrawReq, catchReady;
   logic [10:0]  spawnX, spawnY;
   logic [2:0]   spawnType;
   logic         spawnAck, spawnDrop, catchValid;
   logic [15:0]  bonusDrawReq, slotActive;
   logic [175:0] slotX, slotY;
   logic [47:0]  slotType;
   logic [3:0]   catchSlot;
   logic [2:0]   catchType;
`ifdef BONUS_MISS_CNT_EN
   logic [7:0]   missCount;
`endif

   typedef struct packed {
      logic [3:0] slot;
      logic [2:0] kind;
   } ev_t;

   ev_t exp_q[$];
   int  n_cmp = 0;
   int  n_err = 0;

   always #5 clk = ~clk;

   bonus_slot_manager dut (
      .clk           (clk),
      .reset         (reset),
      .startOfFrame  (startOfFrame),
      .spawnReq      (spawnReq),
      .spawnX        (spawnX),
      .spawnY        (spawnY),
      .spawnType     (spawnType),
      .spawnAck      (spawnAck),
      .spawnDrop     (spawnDrop),
      .bonusDrawReq  (bonusDrawReq),
      .paddleDrawReq (paddleDrawReq),
      .slotActive    (slotActive),
      .slotX         (slotX),
      .slotY         (slotY),
      .slotType      (slotType),
      .catchValid    (catchValid),
      .catchSlot     (catchSlot),
      .catchType     (catchType),
      .catchReady    (catchReady)
`ifdef BONUS_MISS_CNT_EN
      ,
      .missCount     (missCount)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [10:0] y_of(input int i);
      return slotY[i*11 +: 11];
   endfunction

   function automatic logic [10:0] x_of(input int i);
      return slotX[i*11 +: 11];
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1; startOfFrame = 1'b0; spawnReq = 1'b0; paddleDrawReq = 1'b0;
      catchReady = 1'b0; bonusDrawReq = '0; spawnX = '0; spawnY = '0; spawnType = '0;
      tick(); tick();
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic spawn(input logic [10:0] x, input logic [10:0] y, input logic [2:0] t,
                        output logic acked, output logic dropped);
      spawnX = x; spawnY = y; spawnType = t; spawnReq = 1'b1;
      acked = 1'b0; dropped = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (spawnAck || spawnDrop) begin
            acked = spawnAck; dropped = spawnDrop;
            break;
         end
      end
      spawnReq = 1'b0;
      check("spawn_resp", 64'(acked | dropped), 64'd1);
      tick();
   endtask

   task automatic frame();
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
   endtask

   task automatic hit(input logic [15:0] vec);
      paddleDrawReq = 1'b1; bonusDrawReq = vec;
      tick();
      paddleDrawReq = 1'b0; bonusDrawReq = '0;
   endtask

   task automatic drain(output int cyc);
      ev_t e;
      catchReady = 1'b1;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 20) begin
         if (catchValid) begin
            e = exp_q.pop_front();
            check("catch_slot", 64'(catchSlot), 64'(e.slot));
            check("catch_type", 64'(catchType), 64'(e.kind));
         end
         tick();
         cyc++;
      end
      catchReady = 1'b0;
      check("drain_left", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      logic a, d;
      int   cyc;

      // reset values
      do_reset();
      check("rst_active", 64'(slotActive), 64'd0);
      check("rst_ack", 64'(spawnAck | spawnDrop), 64'd0);
      check("rst_cvalid", 64'(catchValid), 64'd0);
      check("rst_slotY", 64'(|slotY), 64'd0);
`ifdef BONUS_MISS_CNT_EN
      check("rst_miss", 64'(missCount), 64'd0);
`endif

      // first spawn: ack and slot visible one cycle after the request
      spawnX = 11'd100; spawnY = 11'd50; spawnType = 3'd2; spawnReq = 1'b1;
      tick();
      check("spawn_ack", 64'(spawnAck), 64'd1);
      check("spawn_active", 64'(slotActive), 64'h0001);
      check("spawn_y0", 64'(y_of(0)), 64'd50);
      check("spawn_x0", 64'(x_of(0)), 64'd100);
      check("spawn_t0", 64'(slotType[2:0]), 64'd2);
      spawnReq = 1'b0;
      tick();
      check("ack_pulse", 64'(spawnAck), 64'd0);

      // fill every slot, then one more is dropped
      for (int i = 1; i < 16; i++) spawn(11'(10 * i), 11'd20, 3'(i % 8), a, d);
      check("full_active", 64'(slotActive), 64'hFFFF);
      check("full_y15", 64'(y_of(15)), 64'd20);
      spawn(11'd1, 11'd1, 3'd1, a, d);
      check("drop_pulse", 64'(d), 64'd1);
      check("drop_no_ack", 64'(a), 64'd0);
      check("drop_active", 64'(slotActive), 64'hFFFF);

      // bottom boundary: 478 misses, 477 lands exactly on 479
      do_reset();
      spawn(11'd0, 11'd478, 3'd1, a, d);
      spawn(11'd0, 11'd477, 3'd1, a, d);
      frame(); tick();
      check("miss_active", 64'(slotActive), 64'h0002);
      check("miss_edge_y", 64'(y_of(1)), 64'd479);
`ifdef BONUS_MISS_CNT_EN
      check("miss_cnt1", 64'(missCount), 64'd1);
`endif
      frame(); tick();
      check("miss_active2", 64'(slotActive), 64'h0000);
`ifdef BONUS_MISS_CNT_EN
      check("miss_cnt2", 64'(missCount), 64'd2);
`endif

      // two overlapping catches held against a stalled consumer
      do_reset();
      for (int i = 0; i < 6; i++) spawn(11'(20 * i), 11'd100, 3'(i), a, d);
      hit(16'h0024);
      exp_q.push_back('{slot: 4'd2, kind: 3'd2});
      exp_q.push_back('{slot: 4'd5, kind: 3'd5});
      frame(); tick();
      for (int k = 0; k < 3; k++) begin
         check("hold_valid", 64'(catchValid), 64'd1);
         check("hold_slot", 64'(catchSlot), 64'(exp_q[0].slot));
         tick();
      end
      check("fall_y0", 64'(y_of(0)), 64'd102);
      check("fall_y3", 64'(y_of(3)), 64'd102);
      check("stop_y2", 64'(y_of(2)), 64'd100);
      check("stop_y5", 64'(y_of(5)), 64'd100);
      drain(cyc);
      check("drain_rate", 64'(cyc), 64'd2);
      check("post_valid", 64'(catchValid), 64'd0);
      check("post_active", 64'(slotActive), 64'h001B);
      spawn(11'd7, 11'd7, 3'd7, a, d);
      check("reuse_active", 64'(slotActive), 64'h001F);
      check("reuse_x2", 64'(x_of(2)), 64'd7);

      // frame during REPORT is replayed after the drain; no paddle means no catch
      do_reset();
      spawn(11'd0, 11'd100, 3'd3, a, d);
      spawn(11'd0, 11'd100, 3'd4, a, d);
      hit(16'h0001);
      bonusDrawReq = 16'h0002; tick(); bonusDrawReq = '0;
      exp_q.push_back('{slot: 4'd0, kind: 3'd3});
      frame(); tick();
      check("rep_valid", 64'(catchValid), 64'd1);
      frame();
      check("rep_stop_y0", 64'(y_of(0)), 64'd100);
      check("rep_fall_y1", 64'(y_of(1)), 64'd102);
      drain(cyc);
      tick(); tick();
      check("pend_y1", 64'(y_of(1)), 64'd104);
      tick(); tick(); tick();
      check("pend_once_y1", 64'(y_of(1)), 64'd104);
      check("pend_active", 64'(slotActive), 64'h0002);
      check("pend_valid", 64'(catchValid), 64'd0);

      // reset in the middle of REPORT
      do_reset();
      for (int i = 0; i < 3; i++) spawn(11'd5, 11'd60, 3'd5, a, d);
      hit(16'h0006);
      frame(); tick();
      check("pre_rst_slot", 64'(catchSlot), 64'd1);
      reset = 1'b1;
      tick();
      check("mid_rst_valid", 64'(catchValid), 64'd0);
      check("mid_rst_slot", 64'(catchSlot), 64'd0);
      check("mid_rst_type", 64'(catchType), 64'd0);
      check("mid_rst_active", 64'(slotActive), 64'd0);
      check("mid_rst_coords", 64'(|{slotX, slotY, slotType}), 64'd0);
      reset = 1'b0;
      exp_q.delete();
      tick();
      check("after_rst_valid", 64'(catchValid), 64'd0);
      spawnX = 11'd9; spawnY = 11'd9; spawnType = 3'd1; spawnReq = 1'b1;
      tick();
      check("after_rst_ack", 64'(spawnAck), 64'd1);
      check("after_rst_active", 64'(slotActive), 64'h0001);
      spawnReq = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
